// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one SRAM write/read port pair between NUM_REQ requesters.
// Read completions return in order and are routed to their issuer through a tag FIFO.
module sram_arbiter #(
   parameter int NUM_REQ            = 4,
   parameter int SRAM_ADDR_WIDTH    = 19,
   parameter int SRAM_DATA_WIDTH    = 72,
   parameter int MAX_RD_OUTSTANDING = 4
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [NUM_REQ-1:0]                   req_wr,
   input  logic [NUM_REQ-1:0]                   req_rd,
   input  logic [NUM_REQ*SRAM_ADDR_WIDTH-1:0]   req_addr,
   input  logic [NUM_REQ*SRAM_DATA_WIDTH-1:0]   req_wr_data,
   output logic [NUM_REQ-1:0]                   req_ack,
   output logic [SRAM_DATA_WIDTH-1:0]           rd_data,
   output logic [NUM_REQ-1:0]                   rd_vld,
   output logic                                 rd_err,
   output logic [SRAM_ADDR_WIDTH-1:0]           wr_0_addr,
   output logic [SRAM_DATA_WIDTH-1:0]           wr_0_data,
   output logic                                 wr_0_req,
   input  logic                                 wr_0_ack,
   output logic [SRAM_ADDR_WIDTH-1:0]           rd_0_addr,
   output logic                                 rd_0_req,
   input  logic                                 rd_0_ack,
   input  logic                                 rd_0_vld,
   input  logic [SRAM_DATA_WIDTH-1:0]           rd_0_data
);

   localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int PTR_W = (MAX_RD_OUTSTANDING > 1) ? $clog2(MAX_RD_OUTSTANDING) : 1;
   localparam int CNT_W = $clog2(MAX_RD_OUTSTANDING) + 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WR   = 2'd1;
   localparam logic [1:0] RD   = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]         state;
   logic [2:0]         last;
   logic [TAG_W-1:0]   idx;
   logic [NUM_REQ-1:0] eligible;
   logic [TAG_W-1:0]   sel;
   logic               found;

   logic [TAG_W-1:0]   tag_mem [MAX_RD_OUTSTANDING];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               fifo_full;
   logic               fifo_empty;
   logic               push;
   logic               pop;

   assign fifo_full  = (count == CNT_W'(MAX_RD_OUTSTANDING));
   assign fifo_empty = (count == '0);
   assign push       = (state == RD) && rd_0_ack;
   assign pop        = rd_0_vld && !fifo_empty;

   // A read only competes while a tag slot is free; writes never stall on the FIFO.
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
         assign eligible[gi] = req_wr[gi] | (req_rd[gi] & ~fifo_full);
      end
   endgenerate

   always_comb begin
      logic [TAG_W-1:0] cand;
      cand  = '0;
      sel   = '0;
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = TAG_W'((int'(last) + k) % NUM_REQ);
         if (!found && eligible[cand]) begin
            sel   = cand;
            found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         last      <= 3'(NUM_REQ - 1);
         idx       <= '0;
         req_ack   <= '0;
         wr_0_req  <= 1'b0;
         rd_0_req  <= 1'b0;
         wr_0_addr <= '0;
         rd_0_addr <= '0;
         wr_0_data <= '0;
      end else begin
         req_ack <= '0;
         case (state)
            IDLE: begin
               if (found) begin
                  idx  <= sel;
                  last <= 3'(sel);
                  // Write wins when a requester holds both; its read waits for a later grant.
                  if (req_wr[sel]) begin
                     state     <= WR;
                     wr_0_req  <= 1'b1;
                     wr_0_addr <= req_addr[sel*SRAM_ADDR_WIDTH +: SRAM_ADDR_WIDTH];
                     wr_0_data <= req_wr_data[sel*SRAM_DATA_WIDTH +: SRAM_DATA_WIDTH];
                  end else begin
                     state     <= RD;
                     rd_0_req  <= 1'b1;
                     rd_0_addr <= req_addr[sel*SRAM_ADDR_WIDTH +: SRAM_ADDR_WIDTH];
                  end
               end
            end
            WR: begin
               if (wr_0_ack) begin
                  wr_0_req <= 1'b0;
                  req_ack  <= NUM_REQ'(1) << idx;
                  state    <= DONE;
               end
            end
            RD: begin
               if (rd_0_ack) begin
                  rd_0_req <= 1'b0;
                  req_ack  <= NUM_REQ'(1) << idx;
                  state    <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         tag_mem[wr_ptr] <= idx;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= (MAX_RD_OUTSTANDING > 1) ? wr_ptr + 1'b1 : '0;
         end
         if (pop) begin
            rd_ptr <= (MAX_RD_OUTSTANDING > 1) ? rd_ptr + 1'b1 : '0;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Return path is independent of the FSM; a return with no tag waiting is flagged, not routed.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_data <= '0;
         rd_vld  <= '0;
         rd_err  <= 1'b0;
      end else begin
         rd_vld <= '0;
         if (pop) begin
            rd_data <= rd_0_data;
            rd_vld  <= NUM_REQ'(1) << tag_mem[rd_ptr];
         end
         if (rd_0_vld && fifo_empty) begin
            rd_err <= 1'b1;
         end
      end
   end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the single user-datapath SRAM port pair (`wr_0_*` / `rd_0_*`) between up to `NUM_REQ` internal requesters, such as flow-table lookup and per-port statistics. Requesters are served one transaction at a time, round-robin. Read completions are routed back to the issuing requester through an in-order tag FIFO. The block sits inside `user_data_path`, between the datapath modules and the top-level SRAM interface.

## Interface

Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `SRAM_ADDR_WIDTH`, 19: SRAM word address width.
- `SRAM_DATA_WIDTH`, 72: SRAM word width (`DATA_WIDTH+CTRL_WIDTH`).
- `MAX_RD_OUTSTANDING`, 4: tag FIFO depth; a power of 2.

Ports:
- `clk`  in  1  single clock for the whole block.
- `reset`  in  1  reset, asynchronous, active-low.
- `req_wr`  in  `NUM_REQ`  per-requester write request; held until the matching `req_ack` bit.
- `req_rd`  in  `NUM_REQ`  per-requester read request; held until the matching `req_ack` bit.
- `req_addr`  in  `NUM_REQ*SRAM_ADDR_WIDTH`  packed addresses; requester i occupies slice i.
- `req_wr_data`  in  `NUM_REQ*SRAM_DATA_WIDTH`  packed write data.
- `req_ack`  out  `NUM_REQ`  one-cycle pulse: the request was accepted by the SRAM.
- `rd_data`  out  `SRAM_DATA_WIDTH`  registered read data, shared by all requesters.
- `rd_vld`  out  `NUM_REQ`  one-cycle pulse: `rd_data` belongs to requester i.
- `rd_err`  out  1  sticky flag: `rd_0_vld` arrived while the tag FIFO was empty.
- `wr_0_addr`, `wr_0_data`, `wr_0_req`  out  widths as the SRAM port  SRAM write side.
- `wr_0_ack`  in  1  SRAM write side acknowledge.
- `rd_0_addr`, `rd_0_req`  out  widths as the SRAM port  SRAM read side.
- `rd_0_ack`, `rd_0_vld`  in  1  SRAM read side acknowledge and data valid.
- `rd_0_data`  in  `SRAM_DATA_WIDTH`  SRAM read data.

## Operation

- Requester i is eligible when `req_wr[i]` is high, or when `req_rd[i]` is high and the tag FIFO is not full.
- Arbitration is round-robin. A 3-bit pointer `last` holds the index of the last granted requester; the search starts at `last+1` and wraps modulo `NUM_REQ`. Reset value of `last` is `NUM_REQ-1`, so requester 0 has first priority.
- If a requester asserts both `req_wr` and `req_rd`, the write is served. The read stays pending for a later grant.
- State machine:
  - IDLE: if any requester is eligible, latch its index, address and data; set `last`; go to WR or RD.
  - WR: `wr_0_req` is high; on `wr_0_ack` go to DONE.
  - RD: `rd_0_req` is high; on `rd_0_ack` push the latched index into the tag FIFO and go to DONE.
  - DONE: `req_ack[idx]` is high for this one cycle; go to IDLE. DONE gives the requester one cycle to drop or change its request before the next arbitration.
- SRAM address and data outputs come from registers that are stable through the whole WR or RD state.
- Tag FIFO: `MAX_RD_OUTSTANDING` entries of ceil(log2(`NUM_REQ`)) bits, with an occupancy counter of width log2(`MAX_RD_OUTSTANDING`)+1.
  - Read and write pointers wrap naturally.
  - A push and a pop in the same cycle leave the count unchanged.
  - When the count equals `MAX_RD_OUTSTANDING`, no read is granted; writes are still granted.
- Read return: on `rd_0_vld` with the FIFO not empty, pop the head tag. On the next cycle, `rd_data` equals the captured `rd_0_data` and `rd_vld[tag]` pulses.
- If `rd_0_vld` arrives with the FIFO empty, no pop occurs, no `rd_vld` pulse is issued, and `rd_err` is set. `rd_err` stays set until reset.
- Reset asserted at any point, including mid-transaction:
  - All state returns to IDLE and the FIFO is cleared.
  - Outstanding reads are discarded; a late `rd_0_vld` after reset sets `rd_err`.

## Timing

- Reset values: `req_ack`=0, `rd_vld`=0, `rd_data`=0, `rd_err`=0, `wr_0_req`=0, `rd_0_req`=0, `wr_0_addr`=0, `rd_0_addr`=0, `wr_0_data`=0.
- Grant latency: request high in cycle t while IDLE -> SRAM req high in cycle t+1.
- `wr_0_ack`/`rd_0_ack` in cycle a -> `req_ack` high in cycle a+1 -> IDLE in cycle a+2.
- Minimum of 3 cycles per transaction when the SRAM acks in the same cycle as its req.
- Read data latency: `rd_0_vld` in cycle v -> `rd_vld` and `rd_data` in cycle v+1.
- The read-return path runs independently of the FSM. Returns may overlap any state, including the DONE state of a read.
- A `req_*` bit that falls before its ack is a protocol violation. The latched transaction still completes.

## Test plan

- Single write: `req_wr`=0001, addr 0x12345, data 0xAA..; SRAM acks immediately -> `wr_0_req` high in cycle 1, `req_ack`=0001 in cycle 2, `wr_0_addr`=0x12345.
- Round-robin: all 4 requesters hold writes, ack immediate -> grant order 0,1,2,3,0; one `req_ack` pulse every 3 cycles.
- Read routing: requesters 2 then 1 each read once; SRAM returns 0x11 then 0x22 with 5-cycle latency -> `rd_vld`=0100 with 0x11, then `rd_vld`=0010 with 0x22.
- FIFO full: 4 reads acked with no `rd_0_vld`; a 5th read and a write pending -> the write is granted, the read stalls; after one `rd_0_vld` the read is granted.
- Write+read same requester: requester 3 has `req_wr`=`req_rd`=1 -> write served first, read served on the next grant to requester 3.
- Reset mid-RD with one read outstanding -> all outputs 0; the following `rd_0_vld` sets `rd_err`=1 and gives no `rd_vld` pulse.
